// File: rtl/test_pkg.sv
// Shared definitions for the packet router: FSM states, the default
// broadcast destination ID and the width of the destination field.
package test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    localparam int          DEST_W   = 8;
    localparam logic [7:0]  BCAST_ID = 8'hFF;

endpackage

// File: rtl/test_if.sv
// Device-side bus of the router.
// pndng/D_pop : per-device "packet pending" flags and FWFT head packets
// pop         : per-device dequeue pulse
// push/D_push : per-device delivery pulse and delivered packet
// master = device side, slave = router side.
interface test_if #(
    parameter int devices = 4,
    parameter int width   = 16
);
    logic [devices-1:0]       pndng;
    logic [devices*width-1:0] D_pop;
    logic [devices-1:0]       pop;
    logic [devices-1:0]       push;
    logic [devices*width-1:0] D_push;

    modport master (
        output pndng, D_pop,
        input  pop, push, D_push
    );

    modport slave (
        input  pndng, D_pop,
        output pop, push, D_push
    );
endinterface

// File: rtl/test_rr_arbiter.sv
// Combinational round-robin selector.
// i_req : request vector, i_ptr : index with highest priority
// o_sel : first requesting index at or after i_ptr (mod N), o_valid : any request
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_sel,
    output logic          o_valid
);
    int w_idx;

    // Scan from the farthest offset down to offset 0 so that the
    // nearest requester at or after the pointer is the last one written.
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_req[w_idx[PW-1:0]]) begin
                o_sel   = w_idx[PW-1:0];
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/test.sv
// Round-robin packet router: pops one packet from a pending device,
// then pushes it to the device(s) named by its destination ID.
// clk, reset (async, active-high), bus (test_if.slave: pndng, D_pop in;
// pop, push, D_push out). All bus outputs are registered.
module test
    import test_pkg::*;
#(
    parameter int         devices   = 4,
    parameter int         width     = 16,
    parameter logic [7:0] broadcast = BCAST_ID
) (
    input  logic   clk,
    input  logic   reset,
    test_if.slave  bus
);
    localparam int PW = $clog2(devices);

    state_t                   r_state, w_state_n;
    logic [devices-1:0]       r_pop, w_pop_n;
    logic [devices-1:0]       r_push, w_push_n;
    logic [devices*width-1:0] r_dpush, w_dpush_n;
    logic [width-1:0]         r_buf, w_buf_n;
    logic [PW-1:0]            r_src, w_src_n;
    logic [PW-1:0]            r_ptr, w_ptr_n;
    logic [PW-1:0]            w_sel;
    logic                     w_valid;

    rr_arbiter #(.N(devices)) u_arb (
        .i_req   (bus.pndng),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_valid (w_valid)
    );

    // Out-of-range destinations and self-addressed packets give an
    // empty mask, so the packet is silently dropped.
    function automatic logic [devices-1:0] target_mask(
        input logic [DEST_W-1:0] dest,
        input logic [PW-1:0]     src
    );
        logic [devices-1:0] m;
        m = '0;
        if (dest == broadcast) begin
            m      = '1;
            m[src] = 1'b0;
        end else if (int'(dest) < devices && dest != DEST_W'(src)) begin
            m[dest[PW-1:0]] = 1'b1;
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pop   <= '0;
            r_push  <= '0;
            r_dpush <= '0;
            r_buf   <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_pop   <= w_pop_n;
            r_push  <= w_push_n;
            r_dpush <= w_dpush_n;
            r_buf   <= w_buf_n;
            r_src   <= w_src_n;
            r_ptr   <= w_ptr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pop_n   = '0;
        w_push_n  = '0;
        w_dpush_n = r_dpush;
        w_buf_n   = r_buf;
        w_src_n   = r_src;
        w_ptr_n   = r_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_buf_n        = bus.D_pop[int'(w_sel)*width +: width];
                    w_src_n        = w_sel;
                    w_pop_n[w_sel] = 1'b1;
                    w_state_n      = ST_POP;
                end
            end
            ST_POP: begin
                w_push_n  = target_mask(r_buf[width-1 -: DEST_W], r_src);
                w_dpush_n = {devices{r_buf}};
                w_state_n = ST_PUSH;
            end
            ST_PUSH: begin
                if (r_src == PW'(devices - 1))
                    w_ptr_n = '0;
                else
                    w_ptr_n = r_src + PW'(1);
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.pop    = r_pop;
    assign bus.push   = r_push;
    assign bus.D_push = r_dpush;
endmodule

// File: tb/tb_test.sv
// Scoreboard bench for the round-robin packet router.
// Devices are modelled as FWFT queues; a monitor checks pop/push events.
module tb_test;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;

    test_if #(.devices(N), .width(W)) bus ();

    test #(.devices(N), .width(W), .broadcast(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pop;
        logic [N-1:0] push;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] devq[N][$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    bit           have_pend = 0;
    exp_t         pend;
    bit           rr_on = 0;
    int           last_pop_cyc = -1;
    int           pop_cnt[N];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Device model: dequeue on pop, present head packet FWFT.
    initial begin
        bus.pndng = '0;
        bus.D_pop = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!reset && bus.pop[i] && devq[i].size() > 0)
                    void'(devq[i].pop_front());
                bus.pndng[i] = devq[i].size() > 0;
                bus.D_pop[i*W +: W] = (devq[i].size() > 0) ? devq[i][0] : '0;
            end
        end
    end

    // Monitor: compare each pop/push event against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                have_pend = 0;
                continue;
            end
            if ((|bus.pop) && (|bus.push))
                check("pop_push_overlap", {bus.pop, bus.push}, '0);
            if (have_pend) begin
                check("push_mask", bus.push, pend.push);
                if (pend.push != '0)
                    for (int i = 0; i < N; i++)
                        check($sformatf("D_push[%0d]", i),
                              bus.D_push[i*W +: W], pend.data);
                have_pend = 0;
            end else if (|bus.push) begin
                check("spurious_push", bus.push, '0);
            end
            if (|bus.pop) begin
                check("pop_onehot", $onehot(bus.pop), 1);
                if (sb.size() == 0) begin
                    check("unexpected_pop", bus.pop, '0);
                end else begin
                    pend = sb.pop_front();
                    check("pop_mask", bus.pop, pend.pop);
                    have_pend = 1;
                    if (rr_on) begin
                        for (int i = 0; i < N; i++)
                            if (bus.pop[i]) pop_cnt[i]++;
                        if (last_pop_cyc >= 0)
                            check("pop_spacing", cyc - last_pop_cyc, 3);
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input int dev, input logic [W-1:0] pkt,
                        input logic [N-1:0] pushm);
        exp_t e;
        e.pop  = N'(1) << dev;
        e.push = pushm;
        e.data = pkt;
        devq[dev].push_back(pkt);
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || have_pend) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 60, 1);
        @(negedge clk);
    endtask

    initial begin
        #1000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) pop_cnt[i] = 0;
        reset = 1'b1;
        #1;
        check("reset_pop", bus.pop, '0);
        check("reset_push", bus.push, '0);
        check("reset_dpush", bus.D_push, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        send(0, 16'h02AB, 4'b0100);
        drain();
        send(1, 16'hFF12, 4'b1101);
        drain();
        send(3, 16'h0755, 4'b0000);
        drain();
        send(2, 16'h0233, 4'b0000);
        drain();

        // Reset in the middle of a transfer: outputs clear at once.
        send(0, 16'hFFAA, 4'b1110);
        begin
            int n;
            n = 0;
            while (n < 20) begin
                @(posedge clk);
                #1;
                n++;
                if (bus.pop[0]) break;
            end
            check("mid_pop_seen", bus.pop[0], 1'b1);
        end
        reset = 1'b1;
        devq[0].delete();
        sb.delete();
        #1;
        check("mid_reset_pop", bus.pop, '0);
        check("mid_reset_push", bus.push, '0);
        check("mid_reset_dpush", bus.D_push, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_push", bus.push, '0);
        check("post_reset_dpush", bus.D_push, '0);

        // All devices pending: order restarts at device 0.
        rr_on = 1;
        send(0, 16'h01A0, 4'b0010);
        send(1, 16'h02B1, 4'b0100);
        send(2, 16'h03C2, 4'b1000);
        send(3, 16'h00D3, 4'b0001);
        send(0, 16'hFFE0, 4'b1110);
        send(1, 16'h0900, 4'b0000);
        send(2, 16'h0111, 4'b0010);
        send(3, 16'h0322, 4'b0000);
        drain();
        rr_on = 0;
        for (int i = 0; i < N; i++)
            check($sformatf("starve_dev%0d", i), pop_cnt[i], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/test.md
TEST -- requirements
Module: test

Interface
REQ-001 Parameter devices, default 4: number of attached device ports; range 2..16.
REQ-002 Parameter width, default 16: packet width in bits; minimum 9.
REQ-003 Parameter broadcast, default 8'hFF: destination ID that addresses every device except the source.
REQ-004 clk  input  1: single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 pndng  input  devices: bit i high means device i holds a packet; the packet is presented first-word-fall-through on D_pop slice i.
REQ-007 D_pop  input  devices*width: slice i (bits i*width +: width) is the head packet of device i.
REQ-008 pop  output  devices: one-cycle pulse that dequeues the head packet of device i.
REQ-009 push  output  devices: one-cycle pulse that delivers a packet to device i.
REQ-010 D_push  output  devices*width: slice i holds the delivered packet and is valid while push[i] is high.

Function
REQ-011 Packet format: bits [width-1:width-8] = destination ID; remaining bits = payload, passed through unmodified.
REQ-012 The block SHALL use a three-state FSM: IDLE, POP, PUSH; all outputs are registered.
REQ-013 IDLE, no pndng bit set: remain in IDLE; pop=0, push=0.
REQ-014 IDLE, any pndng bit set: grant sel = first set index at or after rr_ptr, searching upward modulo devices.
REQ-015 On the granting edge: latch D_pop[sel] into buf and src=sel; enter POP; pop[sel]=1 for exactly that one cycle.
REQ-016 POP -> PUSH unconditionally; on the entering edge compute the target mask.
REQ-017 Target mask, dest=broadcast: every bit set except src.
REQ-018 Target mask, dest<devices and dest!=src: only bit dest set.
REQ-019 Target mask, any other dest (out of range, or equal to src): all zero; packet is dropped silently.
REQ-020 PUSH: push=mask for exactly one cycle; every D_push slice = buf.
REQ-021 PUSH -> IDLE unconditionally; rr_ptr := (src+1) mod devices.
REQ-022 Timing: one packet per 3 cycles; a pop pulse follows one edge after pndng is sampled high; push follows pop by one cycle.
REQ-023 pndng changing during POP or PUSH SHALL be ignored until the FSM returns to IDLE.
REQ-024 At most one pop bit SHALL be high in any cycle; pop and push are never high in the same cycle.
REQ-025 D_push SHALL hold its last value outside PUSH.

Reset
REQ-026 reset high SHALL immediately force: state=IDLE, pop=0, push=0, D_push=0, buf=0, src=0, rr_ptr=0.
REQ-027 Reset asserted mid-transfer SHALL abort it: the latched packet is lost and is neither pushed nor popped again.
REQ-028 After reset deasserts, arbitration restarts at device 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the default broadcast ID constant, and the destination-field width (8).
REQ-030 The block SHALL use one sub-module, rr_arbiter: combinational round-robin selection from pndng and rr_ptr, producing sel and a valid flag.

Verification
REQ-031 Reset check: assert reset mid-run -> pop=0000, push=0000, D_push=0 immediately.
REQ-032 Unicast: dev0 presents 16'h02AB with pndng=0001 -> pop=0001 for one cycle, next cycle push=0100 and D_push[2]=16'h02AB.
REQ-033 Broadcast: dev1 presents 16'hFF12 -> pop=0010, then push=1101 with all D_push slices = 16'hFF12.
REQ-034 Drop cases: dev3 presents 16'h0755 (out-of-range dest) -> pop=1000, then push=0000; dev2 presents 16'h0233 (dest = src) -> pop=0100, then push=0000.
REQ-035 Round-robin: pndng=1111 held high -> pop pulses in order 0,1,2,3,0, each 3 cycles apart.
REQ-036 Bench run limit: 1000 ns at a 10 ns clock period; the bench checks that no device is starved within that window.
